bcd_seven_seg_scanner: RTL and testbench

//  Downstream consumer of the 5-bit binary-to-BCD converter. Takes the 8-bit packed BCD

---
 rtl/bcd_display_pkg.sv | 20 ++
 rtl/bcd_to_seven_seg.sv | 18 +
 rtl/bcd_seven_seg_scanner.sv | 138 +++++++++++++
 tb/tb_bcd_seven_seg_scanner.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/bcd_display_pkg.sv
// Shared types and glyph constants for the two-digit BCD seven-segment scanner.
// Glyphs are active-high, bit order gfedcba.
package bcd_display_pkg;

   typedef enum logic [1:0] {
      BLANK_TO_UNITS = 2'd0,
      UNITS_ON       = 2'd1,
      BLANK_TO_TENS  = 2'd2,
      TENS_ON        = 2'd3
   } scan_state_t;

   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_DASH  = 7'h40;

   localparam logic [6:0] SEG_GLYPH [0:9] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

endpackage

// File: rtl/bcd_to_seven_seg.sv
// Combinational nibble-to-glyph decoder; anything above 9 renders as a dash.
module bcd_to_seven_seg
   import bcd_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      for (int i = 0; i < 10; i++) begin
         if (nibble == 4'(i)) begin
            seg = SEG_GLYPH[i];
         end
      end
   end

endmodule

// File: rtl/bcd_seven_seg_scanner.sv
// Two-digit multiplexed seven-segment driver with a one-entry load buffer,
// leading-zero blanking on the tens digit and blank gaps between digit slots.
module bcd_seven_seg_scanner
   import bcd_display_pkg::*;
#(
   parameter int REFRESH_DIV    = 8,
   parameter int BLANK_CYCLES   = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b0
)
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] bcd_input,
   input  logic       load_valid,
   output logic       load_ready,
   output logic [6:0] seg_out,
   output logic [1:0] digit_en,
   output logic       invalid_digit
);

   localparam int MAX_CYC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC);
   localparam logic [CNT_W-1:0] LIT_LAST   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [6:0] SEG_OFF   = SEG_BLANK ^ {7{SEG_ACTIVE_LOW}};
   localparam logic [1:0] DIGIT_OFF = 2'b00 ^ {2{SEG_ACTIVE_LOW}};

   scan_state_t      state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             slot_last;

   logic [7:0] pending_reg;
   logic       pending_valid_reg;
   logic [7:0] display_reg;
   logic       load_ready_reg;
   logic       invalid_reg;
   logic [6:0] seg_out_reg;
   logic [1:0] digit_en_reg;

   logic [3:0] nibble_sel;
   logic [6:0] dec_seg;
   logic [6:0] seg_next;
   logic [1:0] digit_next;
   logic       load_fire;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg <= BLANK_TO_UNITS;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + CNT_W'(1);
      slot_last  = 1'b0;
      case (state_reg)
         BLANK_TO_UNITS: if (cnt_reg == BLANK_LAST) begin
            state_next = UNITS_ON;
            cnt_next   = '0;
         end
         UNITS_ON: if (cnt_reg == LIT_LAST) begin
            state_next = BLANK_TO_TENS;
            cnt_next   = '0;
            slot_last  = 1'b1;
         end
         BLANK_TO_TENS: if (cnt_reg == BLANK_LAST) begin
            state_next = TENS_ON;
            cnt_next   = '0;
         end
         TENS_ON: if (cnt_reg == LIT_LAST) begin
            state_next = BLANK_TO_UNITS;
            cnt_next   = '0;
            slot_last  = 1'b1;
         end
         default: begin
            state_next = BLANK_TO_UNITS;
            cnt_next   = '0;
         end
      endcase
   end

   // Single decoder shared by both digits; the nibble follows the current slot.
   assign nibble_sel = (state_reg == TENS_ON) ? display_reg[7:4] : display_reg[3:0];

   bcd_to_seven_seg u_decoder (
      .nibble (nibble_sel),
      .seg    (dec_seg)
   );

   always_comb begin
      digit_next = 2'b00;
      if (state_reg == UNITS_ON) begin
         digit_next = 2'b01;
      end else if (state_reg == TENS_ON && display_reg[7:4] != 4'd0) begin
         digit_next = 2'b10;
      end
      seg_next = (digit_next != 2'b00) ? dec_seg : SEG_BLANK;
   end

   // load_ready mirrors "pending empty", so a fire never coincides with a drain.
   assign load_fire = load_valid && load_ready_reg;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pending_reg       <= 8'h00;
         pending_valid_reg <= 1'b0;
         display_reg       <= 8'h00;
         invalid_reg       <= 1'b0;
         load_ready_reg    <= 1'b1;
         seg_out_reg       <= SEG_OFF;
         digit_en_reg      <= DIGIT_OFF;
      end else begin
         if (load_fire) begin
            pending_reg       <= bcd_input;
            pending_valid_reg <= 1'b1;
         end else if (slot_last && pending_valid_reg) begin
            pending_valid_reg <= 1'b0;
         end
         if (slot_last && pending_valid_reg) begin
            display_reg <= pending_reg;
            invalid_reg <= (pending_reg[7:4] > 4'd9) || (pending_reg[3:0] > 4'd9);
         end
         load_ready_reg <= !(load_fire || (pending_valid_reg && !slot_last));
         seg_out_reg    <= seg_next ^ {7{SEG_ACTIVE_LOW}};
         digit_en_reg   <= digit_next ^ {2{SEG_ACTIVE_LOW}};
      end
   end

   assign load_ready    = load_ready_reg;
   assign seg_out       = seg_out_reg;
   assign digit_en      = digit_en_reg;
   assign invalid_digit = invalid_reg;

endmodule

// File: tb/tb_bcd_seven_seg_scanner.sv
// Self-checking bench: directed and random loads against a cycle-position reference
// model of the scan schedule and the one-entry load buffer.
module tb_bcd_seven_seg_scanner;

   localparam int R = 8;
   localparam int B = 2;
   localparam int P = 2 * (R + B);

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] bcd_input = 8'h00;
   logic       load_valid = 1'b0;
   logic       load_ready;
   logic [6:0] seg_out;
   logic [1:0] digit_en;
   logic       invalid_digit;

   bcd_seven_seg_scanner #(
      .REFRESH_DIV    (R),
      .BLANK_CYCLES   (B),
      .SEG_ACTIVE_LOW (1'b0)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .bcd_input     (bcd_input),
      .load_valid    (load_valid),
      .load_ready    (load_ready),
      .seg_out       (seg_out),
      .digit_en      (digit_en),
      .invalid_digit (invalid_digit)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model: position inside the repeating scan period plus buffer contents.
   int k_cyc = 0;
   int pend = -1;
   int disp = 0;
   int exp_seg, exp_dig, exp_rdy, exp_inv;
   bit fired;
   int glyph_tab [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

   function automatic int glyph(int n);
      return (n > 9) ? 'h40 : glyph_tab[n];
   endfunction

   task automatic check_value(string tag, int obs, int expv);
      checks++;
      if (obs != expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, k_cyc);
      end
   endtask

   task automatic step();
      int ph;
      @(posedge clock);
      fired = 1'b0;
      if (!reset_n) begin
         k_cyc = 0; pend = -1; disp = 0;
         exp_seg = 0; exp_dig = 0; exp_rdy = 1; exp_inv = 0;
      end else begin
         ph = k_cyc % P;
         exp_dig = 0;
         exp_seg = 0;
         if (ph >= B && ph < B + R) begin
            exp_dig = 1;
            exp_seg = glyph(disp % 16);
         end else if (ph >= 2 * B + R && (disp / 16) != 0) begin
            exp_dig = 2;
            exp_seg = glyph(disp / 16);
         end
         if ((ph == B + R - 1 || ph == P - 1) && pend >= 0) begin
            $display("show %02h at cycle %0d", pend, k_cyc);
            disp = pend;
            pend = -1;
         end else if (load_valid && pend < 0) begin
            pend = int'(bcd_input);
            fired = 1'b1;
            $display("load %02h accepted at cycle %0d", bcd_input, k_cyc);
         end
         exp_rdy = (pend < 0) ? 1 : 0;
         exp_inv = ((disp / 16) > 9 || (disp % 16) > 9) ? 1 : 0;
         k_cyc++;
      end
      #1;
      check_value("seg_out", int'(seg_out), exp_seg);
      check_value("digit_en", int'(digit_en), exp_dig);
      check_value("load_ready", int'(load_ready), exp_rdy);
      check_value("invalid_digit", int'(invalid_digit), exp_inv);
      check_value("digit_en_not_11", int'(digit_en == 2'b11), 0);
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic load_value(logic [7:0] v);
      int waited;
      waited = 0;
      bcd_input = v;
      load_valid = 1'b1;
      do begin
         step();
         waited++;
      end while (!fired && waited < 100);
      check_value("load_accept_timeout", int'(fired), 1);
      load_valid = 1'b0;
   endtask

   initial begin
      int edge_no;
      int first_units;

      // Reset state
      reset_n = 1'b0;
      run(3);
      check_value("reset_ready", int'(load_ready), 1);
      check_value("reset_digit", int'(digit_en), 0);

      // Edge 1 is the last edge that samples reset low.
      reset_n = 1'b1;
      edge_no = 1;
      first_units = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         edge_no++;
         if (first_units == 0 && digit_en == 2'b01) first_units = edge_no;
      end
      check_value("first_units_edge", first_units, 4);

      load_value(8'h13); run(45);
      load_value(8'h09); run(45);
      load_value(8'h13); load_value(8'h27); run(50);
      load_value(8'h1F); run(45);
      check_value("invalid_after_1F", int'(invalid_digit), 1);
      load_value(8'h00); run(45);
      check_value("invalid_after_00", int'(invalid_digit), 0);

      // Reset in the middle of UNITS_ON while a value is still pending.
      load_value(8'h55);
      run($urandom_range(0, 3));
      while ((k_cyc % P) != 0) step();
      load_value(8'h48);
      while ((k_cyc % P) != B + 3) step();
      check_value("pending_before_reset", int'(load_ready), 0);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      run(45);

      // Random traffic, including non-decimal nibbles.
      for (int i = 0; i < 600; i++) begin
         load_valid = ($urandom_range(0, 9) < 3);
         bcd_input  = 8'($urandom);
         step();
      end
      load_valid = 1'b0;
      run(45);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
